pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage RV32 pipeline. It replaces the separate forwarding and load-use units: it adds multi-cycle EX operations, variable-latency data-memory wait states with a timeout, and branch/jump flush control. Saturating stall and flush performance counters are included. It sits beside the pipeline registers and drives all hold, bubble, flush and forwarding selects.

---
 rtl/pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and forwarding controller for the 5-stage RV32 pipeline. It covers
// operand forwarding, load-use stalls, multi-cycle EX ops, data-memory wait
// states with a timeout flag, and branch/jump flushes, and it keeps
// saturating stall and flush counters.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   rs1/rs2_addr_id        sources of the instruction in ID
//   rd_addr_ex, reg_write_en_ex, MemRead_ex, mc_op_ex, branch_taken_ex,
//   rs1/rs2_addr_ex        EX-stage destination, controls and sources
//   rd_addr_mem, reg_write_en_mem, dmem_req_mem, dmem_ready  MEM writer / dmem handshake
//   rd_addr_wb, reg_write_en_wb                               WB writer
//   cnt_clr                synchronous clear of both performance counters
//   forward_a/b            00 regfile, 10 MEM result, 01 WB data
//   hold_*                 pipeline register keeps its value
//   flush_*, bubble_*      pipeline register loads a NOP
//   mc_busy                multi-cycle op occupying EX
//   mem_err                sticky dmem timeout flag
//   stall_cnt, flush_cnt   saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MC_LAT      = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_id,
    input  logic [REG_AW-1:0] rs2_addr_id,
    input  logic [REG_AW-1:0] rd_addr_ex,
    input  logic              reg_write_en_ex,
    input  logic              MemRead_ex,
    input  logic              mc_op_ex,
    input  logic              branch_taken_ex,
    input  logic [REG_AW-1:0] rs1_addr_ex,
    input  logic [REG_AW-1:0] rs2_addr_ex,
    input  logic [REG_AW-1:0] rd_addr_mem,
    input  logic              reg_write_en_mem,
    input  logic              dmem_req_mem,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rd_addr_wb,
    input  logic              reg_write_en_wb,
    input  logic              cnt_clr,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              hold_pc,
    output logic              hold_if_id,
    output logic              hold_id_ex,
    output logic              hold_ex_mem,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              bubble_ex_mem,
    output logic              bubble_mem_wb,
    output logic              mc_busy,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MC_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 1);
    localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {S_RUN, S_MC_BUSY, S_MEM_WAIT} state_t;

    state_t          state, state_n, eff_state;
    logic [MC_W-1:0] mc_cnt, mc_cnt_n, mc_eff;
    logic [WT_W-1:0] wait_cnt, wait_n;
    logic            resume_mc, resume_n;
    logic            err_n;
    logic            freeze, load_use, busy, branch_flush;

    // The EX write enable is not needed: a load always writes its rd.
    logic unused_inputs;
    assign unused_inputs = reg_write_en_ex;

    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (rst) begin
            if (reg_write_en_mem && rd_addr_mem != '0 && rd_addr_mem == rs1_addr_ex)
                forward_a = 2'b10;
            else if (reg_write_en_wb && rd_addr_wb != '0 && rd_addr_wb == rs1_addr_ex)
                forward_a = 2'b01;
            if (reg_write_en_mem && rd_addr_mem != '0 && rd_addr_mem == rs2_addr_ex)
                forward_b = 2'b10;
            else if (reg_write_en_wb && rd_addr_wb != '0 && rd_addr_wb == rs2_addr_ex)
                forward_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            mc_cnt    <= '0;
            wait_cnt  <= '0;
            resume_mc <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_n;
            mc_cnt    <= mc_cnt_n;
            wait_cnt  <= wait_n;
            resume_mc <= resume_n;
            mem_err   <= err_n;
        end
    end

    always_comb begin
        freeze   = dmem_req_mem && !dmem_ready;
        load_use = MemRead_ex && rd_addr_ex != '0 &&
                   (rd_addr_ex == rs1_addr_id || rd_addr_ex == rs2_addr_id);

        // The ready cycle of a memory wait already behaves like the state it
        // resumes to, so a pending multi-cycle op keeps stalling without a gap.
        eff_state = state;
        if (state == S_MEM_WAIT)
            eff_state = resume_mc ? S_MC_BUSY : S_RUN;

        // A new op in RUN counts as already loaded, giving zero-cycle response;
        // the register then holds the remaining count after this cycle.
        mc_eff = '0;
        if (eff_state == S_RUN && mc_op_ex)
            mc_eff = MC_LOAD;
        else if (eff_state == S_MC_BUSY)
            mc_eff = mc_cnt;
        busy = (mc_eff != '0);

        state_n  = state;
        mc_cnt_n = mc_cnt;
        wait_n   = wait_cnt;
        resume_n = resume_mc;
        err_n    = mem_err;

        if (freeze) begin
            state_n = S_MEM_WAIT;
            if (state != S_MEM_WAIT)
                resume_n = (state == S_MC_BUSY);
            if (wait_cnt != WT_MAX)
                wait_n = wait_cnt + WT_W'(1);
            if (wait_n == WT_MAX)
                err_n = 1'b1;
        end else begin
            wait_n   = '0;
            resume_n = 1'b0;
            if (eff_state == S_MC_BUSY) begin
                // Stay in MC_BUSY through the count-0 cycle so the op still in
                // EX is not reloaded as a new one.
                if (mc_cnt != '0) begin
                    state_n  = S_MC_BUSY;
                    mc_cnt_n = mc_cnt - MC_W'(1);
                end else begin
                    state_n = S_RUN;
                end
            end else if (busy) begin
                state_n  = S_MC_BUSY;
                mc_cnt_n = mc_eff - MC_W'(1);
            end else begin
                state_n  = S_RUN;
                mc_cnt_n = '0;
            end
        end

        hold_pc       = 1'b0;
        hold_if_id    = 1'b0;
        hold_id_ex    = 1'b0;
        hold_ex_mem   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        bubble_mem_wb = 1'b0;
        branch_flush  = 1'b0;
        mc_busy       = 1'b0;

        if (rst) begin
            mc_busy = busy;
            if (freeze) begin
                hold_pc       = 1'b1;
                hold_if_id    = 1'b1;
                hold_id_ex    = 1'b1;
                hold_ex_mem   = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (busy) begin
                hold_pc       = 1'b1;
                hold_if_id    = 1'b1;
                hold_id_ex    = 1'b1;
                bubble_ex_mem = 1'b1;
            end else if (branch_taken_ex) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                hold_pc     = 1'b1;
                hold_if_id  = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MC_LAT=4, MEM_TIMEOUT=4, CNT_W=2.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_id, rs2_addr_id, rd_addr_ex, rs1_addr_ex, rs2_addr_ex;
    logic [4:0] rd_addr_mem, rd_addr_wb;
    logic       reg_write_en_ex, MemRead_ex, mc_op_ex, branch_taken_ex;
    logic       reg_write_en_mem, dmem_req_mem, dmem_ready, reg_write_en_wb, cnt_clr;
    logic [1:0] forward_a, forward_b;
    logic       hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic       flush_if_id, flush_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic       mc_busy, mem_err;
    logic [1:0] stall_cnt, flush_cnt;
    logic [7:0] ctl;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [7:0] CTL_LU   = 8'b1100_0100;
    localparam logic [7:0] CTL_BR   = 8'b0000_1100;
    localparam logic [7:0] CTL_MC   = 8'b1110_0010;
    localparam logic [7:0] CTL_FRZ  = 8'b1111_0001;
    localparam logic [7:0] CTL_NONE = 8'b0000_0000;

    pipeline_hazard_ctrl #(
        .REG_AW      (5),
        .MC_LAT      (4),
        .MEM_TIMEOUT (4),
        .CNT_W       (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_addr_id      (rs1_addr_id),
        .rs2_addr_id      (rs2_addr_id),
        .rd_addr_ex       (rd_addr_ex),
        .reg_write_en_ex  (reg_write_en_ex),
        .MemRead_ex       (MemRead_ex),
        .mc_op_ex         (mc_op_ex),
        .branch_taken_ex  (branch_taken_ex),
        .rs1_addr_ex      (rs1_addr_ex),
        .rs2_addr_ex      (rs2_addr_ex),
        .rd_addr_mem      (rd_addr_mem),
        .reg_write_en_mem (reg_write_en_mem),
        .dmem_req_mem     (dmem_req_mem),
        .dmem_ready       (dmem_ready),
        .rd_addr_wb       (rd_addr_wb),
        .reg_write_en_wb  (reg_write_en_wb),
        .cnt_clr          (cnt_clr),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .hold_pc          (hold_pc),
        .hold_if_id       (hold_if_id),
        .hold_id_ex       (hold_id_ex),
        .hold_ex_mem      (hold_ex_mem),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .bubble_ex_mem    (bubble_ex_mem),
        .bubble_mem_wb    (bubble_mem_wb),
        .mc_busy          (mc_busy),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    assign ctl = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                  flush_if_id, flush_id_ex, bubble_ex_mem, bubble_mem_wb};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_ex = '0;
        rs1_addr_ex = '0; rs2_addr_ex = '0; rd_addr_mem = '0; rd_addr_wb = '0;
        reg_write_en_ex = 0; MemRead_ex = 0; mc_op_ex = 0; branch_taken_ex = 0;
        reg_write_en_mem = 0; dmem_req_mem = 0; dmem_ready = 0;
        reg_write_en_wb = 0; cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazard-triggering inputs: all outputs must still be quiet.
        rst = 1'b0;
        idle();
        rs1_addr_ex = 5; rd_addr_mem = 5; reg_write_en_mem = 1; mc_op_ex = 1;
        #3;
        check("rst_ctl", ctl, CTL_NONE);
        check("rst_fwd", {forward_a, forward_b}, 4'b0000);
        check("rst_mc_busy", mc_busy, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 4'b0000);
        #9;
        idle();
        rst = 1'b1;
        tick();

        // Forwarding: MEM over WB, x0 never, WB alone.
        rs1_addr_ex = 5; rs2_addr_ex = 7; rd_addr_mem = 5; reg_write_en_mem = 1;
        rd_addr_wb = 5; reg_write_en_wb = 1;
        #1;
        check("fwd_a_mem_prio", forward_a, 2'b10);
        check("fwd_b_none", forward_b, 2'b00);
        rd_addr_mem = 0; rd_addr_wb = 0; rs1_addr_ex = 0;
        #1;
        check("fwd_a_x0", forward_a, 2'b00);
        reg_write_en_mem = 0; rd_addr_mem = 5; rd_addr_wb = 5;
        rs1_addr_ex = 5; rs2_addr_ex = 5;
        #1;
        check("fwd_ab_wb", {forward_a, forward_b}, 4'b0101);
        idle();
        tick();

        // Load-use: lw x3 in EX, add x4,x3,x1 in ID.
        MemRead_ex = 1; reg_write_en_ex = 1; rd_addr_ex = 3;
        rs1_addr_id = 3; rs2_addr_id = 1;
        #1;
        check("lu_ctl", ctl, CTL_LU);
        tick();
        idle();
        rs1_addr_id = 3; rs2_addr_id = 1; rd_addr_mem = 3; reg_write_en_mem = 1;
        #1;
        check("lu_one_bubble", ctl, CTL_NONE);
        check("lu_stall_cnt", stall_cnt, 1);
        tick();
        idle();
        rs1_addr_ex = 3; rs2_addr_ex = 1; rd_addr_wb = 3; reg_write_en_wb = 1;
        #1;
        check("lu_fwd_wb", {forward_a, forward_b}, 4'b0100);
        tick();
        idle();
        MemRead_ex = 1; rd_addr_ex = 6; rs1_addr_id = 2; rs2_addr_id = 6;
        #1;
        check("lu_rs2_ctl", ctl, CTL_LU);
        tick();
        idle();
        MemRead_ex = 1; rd_addr_ex = 0; rs1_addr_id = 0;
        #1;
        check("lu_x0_ctl", ctl, CTL_NONE);
        check("lu_stall_cnt2", stall_cnt, 2);
        tick();

        // Branch overrides a simultaneous load-use.
        idle();
        branch_taken_ex = 1; MemRead_ex = 1; rd_addr_ex = 3; rs1_addr_id = 3;
        #1;
        check("br_ctl", ctl, CTL_BR);
        tick();
        idle();
        #1;
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);

        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        #1;
        check("clr_cnts", {stall_cnt, flush_cnt}, 4'b0000);

        // Multi-cycle op, MC_LAT=4: three stall cycles, leaves in cycle four.
        mc_op_ex = 1; reg_write_en_ex = 1; rd_addr_ex = 9;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mc_ctl", ctl, CTL_MC);
            check("mc_busy_on", mc_busy, 1);
            tick();
        end
        check("mc_leave_ctl", ctl, CTL_NONE);
        check("mc_busy_off", mc_busy, 0);
        tick();
        mc_op_ex = 0;
        #1;
        check("mc_stall_cnt", stall_cnt, 3);

        cnt_clr = 1;
        tick();
        cnt_clr = 0;

        // Memory wait, 5 frozen cycles; a branch during the freeze is ignored.
        dmem_req_mem = 1; dmem_ready = 0; branch_taken_ex = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_ctl", ctl, CTL_FRZ);
            check("frz_mem_err", mem_err, (i == 4) ? 1 : 0);
            tick();
        end
        branch_taken_ex = 0; dmem_ready = 1;
        #1;
        check("frz_ready_ctl", ctl, CTL_NONE);
        check("frz_err_sticky", mem_err, 1);
        tick();
        idle();
        #1;
        check("frz_err_after", mem_err, 1);
        check("sat_stall_cnt", stall_cnt, 3);
        check("frz_no_flush", flush_cnt, 0);

        // Clear beats a same-cycle stall; RUN handles load-use again.
        MemRead_ex = 1; rd_addr_ex = 4; rs1_addr_id = 4; cnt_clr = 1;
        #1;
        check("run_lu_ctl", ctl, CTL_LU);
        tick();
        idle();
        #1;
        check("clr_wins", stall_cnt, 0);

        // Freeze in the middle of a multi-cycle op resumes the remaining count.
        mc_op_ex = 1;
        #1;
        check("mcf_c1", ctl, CTL_MC);
        tick();
        dmem_req_mem = 1; dmem_ready = 0;
        #1;
        check("mcf_frz", ctl, CTL_FRZ);
        tick();
        dmem_ready = 1;
        #1;
        check("mcf_resume", {ctl, 7'b0, mc_busy}, {CTL_MC, 8'h01});
        tick();
        dmem_req_mem = 0; dmem_ready = 0;
        #1;
        check("mcf_c4", ctl, CTL_MC);
        tick();
        check("mcf_leave", {ctl, 7'b0, mc_busy}, {CTL_NONE, 8'h00});
        tick();
        idle();

        // Reset while MC_BUSY.
        mc_op_ex = 1;
        #1;
        tick();
        check("rmc_busy_before", mc_busy, 1);
        rst = 0;
        #1;
        check("rmc_busy_rst", mc_busy, 0);
        check("rmc_ctl_rst", ctl, CTL_NONE);
        check("rmc_err_rst", mem_err, 0);
        rst = 1; mc_op_ex = 0;
        #1;
        check("rmc_run", mc_busy, 0);
        tick();
        check("rmc_run_next", {ctl, 7'b0, mc_busy}, {CTL_NONE, 8'h00});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
